shift_sub_divider: RTL and testbench

SHIFT_SUB_DIVIDER -- requirements
Module: shift_sub_divider

---
 rtl/shift_sub_divider.sv | 122 ++++++++++++
 tb/tb_shift_sub_divider.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/shift_sub_divider.sv
// Unsigned restoring shift-subtract divider: 2N-bit dividend / N-bit divisor,
// one quotient bit per cycle, with overflow detection at request acceptance.
module shift_sub_divider #(
  parameter int unsigned N = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [2*N-1:0]   dividend_i,
  input  logic [N-1:0]     divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             v_o,
  output logic [N-1:0]     quotient_o,
  output logic [N-1:0]     remainder_o
);

  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [2*N:0]    acc_q, acc_d;
  logic [N-1:0]    div_q, div_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            v_q, v_d;
  logic [N-1:0]    quo_q, quo_d;
  logic [N-1:0]    rem_q, rem_d;
  logic [2*N:0]    trial;
  logic            ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      v_q     <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      v_q     <= v_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
    end
  end

  // The accumulator top bit is always 0 between iterations, so shifting the
  // whole register is identical to {acc[2N-1:0], 1'b0}.
  always_comb begin
    trial = acc_q << 1;
    if (trial[2*N:N] >= {1'b0, div_q}) begin
      trial[2*N:N] = trial[2*N:N] - {1'b0, div_q};
      trial[0]     = 1'b1;
    end
  end

  assign ovf = (dividend_i[2*N-1:N] >= divisor_i);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    v_d     = v_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (ovf) begin
            v_d    = 1'b1;
            quo_d  = '0;
            rem_d  = '0;
            done_d = 1'b1;
          end else begin
            acc_d   = {1'b0, dividend_i};
            div_d   = divisor_i;
            cnt_d   = '0;
            v_d     = 1'b0;
            busy_d  = 1'b1;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        acc_d = trial;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          quo_d   = trial[N-1:0];
          rem_d   = trial[2*N-1:N];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign v_o         = v_q;
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: tb/tb_shift_sub_divider.sv
// Scoreboard bench for shift_sub_divider (N=4): directed cases, ignored starts,
// back-to-back requests, mid-run reset and a random regression.
module tb_shift_sub_divider;

  localparam int unsigned N  = 4;
  localparam int unsigned W2 = 2 * N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic [W2-1:0] dividend_i = '0;
  logic [N-1:0]  divisor_i = '0;
  logic          busy_o, done_o, v_o;
  logic [N-1:0]  quotient_o, remainder_o;

  shift_sub_divider #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .v_o         (v_o),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic         v;
    logic [N-1:0] q;
    logic [N-1:0] r;
    int           due;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  logic [N-1:0] hold_q = '0;
  logic [N-1:0] hold_r = '0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [W2-1:0] dd, input logic [N-1:0] dv);
    exp_t        e;
    logic        ovf;
    int unsigned a, b;
    a   = dd;
    b   = dv;
    ovf = (dd[W2-1:N] >= dv);
    e.v = ovf;
    if (ovf) begin
      e.q = '0;
      e.r = '0;
    end else begin
      e.q = N'(a / b);
      e.r = N'(a % b);
    end
    start_i    = 1'b1;
    dividend_i = dd;
    divisor_i  = dv;
    @(posedge clk);
    #1;
    e.due = cyc + (ovf ? 0 : int'(N));
    sb.push_back(e);
    check_eq("busy_after_accept", busy_o, !ovf);
    start_i    = 1'b0;
    dividend_i = W2'($urandom);
    divisor_i  = N'($urandom);
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 4 * N + 8 && !seen; i++) begin
      @(negedge clk);
      if (done_o) seen = 1'b1;
    end
    check_eq(tag, seen, 1);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      hold_q = '0;
      hold_r = '0;
    end else if (done_o) begin
      check_eq("done_busy_excl", busy_o, 0);
      if (sb.size() == 0) begin
        check_eq("spurious_done", done_o, 0);
      end else begin
        e = sb.pop_front();
        check_eq("v", v_o, e.v);
        check_eq("quotient", quotient_o, e.q);
        check_eq("remainder", remainder_o, e.r);
        check_eq("latency", cyc, e.due);
        hold_q = e.q;
        hold_r = e.r;
      end
    end else begin
      check_eq("hold_q", quotient_o, hold_q);
      check_eq("hold_r", remainder_o, hold_r);
      if (busy_o) check_eq("v_clear_busy", v_o, 0);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #12;
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_done", done_o, 0);
    check_eq("rst_v", v_o, 0);
    check_eq("rst_q", quotient_o, 0);
    check_eq("rst_r", remainder_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(8'd135, 4'd13); wait_done("done_135_13");
    issue(8'd239, 4'd15); wait_done("done_239_15");
    issue(8'd0,   4'd1);  wait_done("done_0_1");
    issue(8'd255, 4'd15); wait_done("done_ovf_255_15");
    issue(8'd200, 4'd0);  wait_done("done_ovf_div0");
    repeat (3) @(negedge clk);

    // Starts during RUN must be ignored.
    issue(8'd135, 4'd13);
    @(negedge clk);
    start_i = 1'b1; dividend_i = 8'd16; divisor_i = 4'd1;
    @(negedge clk);
    @(negedge clk);
    start_i = 1'b0;
    wait_done("done_ignored_start");
    repeat (2) @(negedge clk);

    issue(8'd135, 4'd13); wait_done("done_b2b_first");
    issue(8'd100, 4'd7);  wait_done("done_b2b_second");

    // Reset after the second iteration aborts without a done pulse.
    issue(8'd135, 4'd13);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    check_eq("midrst_busy", busy_o, 0);
    check_eq("midrst_done", done_o, 0);
    check_eq("midrst_v", v_o, 0);
    check_eq("midrst_q", quotient_o, 0);
    check_eq("midrst_r", remainder_o, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(8'd50, 4'd6); wait_done("done_after_reset");

    for (int k = 0; k < 60; k++) begin
      issue(W2'($urandom), N'($urandom));
      wait_done("done_random");
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check_eq("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
